intra16_mb_scheduler: RTL and testbench

Frame-level sequencer for Intra 16x16 luma prediction. For each macroblock in raster order it does four things:
- starts the predictor/SAD unit and waits for its completion;
- picks the best of the vertical, horizontal and DC modes by minimum SAD;
- records the chosen mode in the mode table;
- streams the 256 residues of that mode into the frame residue buffer, with backpressure.

It sits between the intra predictor/SAD units and the residue/mode storage, replacing the free-running per-MB decision logic.

---
 rtl/intra16_mb_scheduler.sv | 176 +++++++++++++++++
 tb/tb_intra16_mb_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra16_mb_scheduler.sv
// Frame-level sequencer for Intra 16x16 luma prediction: walks the macroblocks in raster
// order, picks the lowest-SAD mode, logs it, and streams that mode's residues to the frame buffer.
module intra16_mb_scheduler #(
  parameter int FRAME_W = 256,
  parameter int FRAME_H = 256,
  parameter int SAD_W   = 16,
  parameter int AW      = $clog2(FRAME_W * FRAME_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  output logic             busy,
  output logic             frame_done,
  output logic             pred_start,
  output logic [12:0]      pred_mb,
  input  logic             pred_done,
  input  logic [SAD_W-1:0] sad_v,
  input  logic [SAD_W-1:0] sad_h,
  input  logic [SAD_W-1:0] sad_dc,
  output logic [1:0]       res_sel,
  output logic [7:0]       res_idx,
  input  logic [7:0]       res_data,
  output logic             fb_we,
  output logic [AW-1:0]    fb_addr,
  output logic [7:0]       fb_data,
  input  logic             fb_ready,
  output logic             mode_we,
  output logic [12:0]      mode_addr,
  output logic [1:0]       mode_data
);

  localparam int MBW      = FRAME_W / 16;
  localparam int MBH      = FRAME_H / 16;
  localparam int MB_TOTAL = MBW * MBH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DECIDE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [12:0]      mb;
  logic [12:0]      mb_row;
  logic [12:0]      mb_col;
  logic [7:0]       idx;
  logic [1:0]       mode_q;
  logic [SAD_W-1:0] sad_v_q;
  logic [SAD_W-1:0] sad_h_q;
  logic [SAD_W-1:0] sad_dc_q;

  // Running minimum with strict-less compares, so ties keep the lower mode code.
  logic [SAD_W-1:0] best;
  logic [1:0]       mode_calc;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    best      = sad_v_q;
    mode_calc = 2'd0;
    if (sad_h_q < best) begin
      best      = sad_h_q;
      mode_calc = 2'd1;
    end
    if (sad_dc_q < best) begin
      mode_calc = 2'd2;
    end
  end

  // Row/column counters track the MB position so the address needs no divider.
  logic [31:0] row_pix;
  logic [31:0] col_pix;

  always_comb begin
    row_pix = 32'(mb_row) * 32'd16 + 32'(idx[7:4]);
    col_pix = 32'(mb_col) * 32'd16 + 32'(idx[3:0]);
  end

  assign fb_addr   = AW'(row_pix * 32'(FRAME_W) + col_pix);
  assign fb_data   = fb_we ? res_data : 8'd0;
  assign pred_mb   = mb;
  assign mode_addr = mb;
  assign mode_data = mode_calc;
  assign res_sel   = mode_q;
  assign res_idx   = idx;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mb         <= '0;
      mb_row     <= '0;
      mb_col     <= '0;
      idx        <= '0;
      mode_q     <= '0;
      sad_v_q    <= '0;
      sad_h_q    <= '0;
      sad_dc_q   <= '0;
      busy       <= 1'b0;
      pred_start <= 1'b0;
      mode_we    <= 1'b0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pred_start <= 1'b0;
      mode_we    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            state      <= S_START;
            mb         <= '0;
            mb_row     <= '0;
            mb_col     <= '0;
            busy       <= 1'b1;
            pred_start <= 1'b1;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (pred_done) begin
            sad_v_q  <= sad_v;
            sad_h_q  <= sad_h;
            sad_dc_q <= sad_dc;
            mode_we  <= 1'b1;
            state    <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          mode_q <= mode_calc;
          idx    <= '0;
          fb_we  <= 1'b1;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (fb_ready) begin
            idx <= idx + 8'd1;
            if (idx == 8'd255) begin
              fb_we <= 1'b0;
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (mb == 13'(MB_TOTAL - 1)) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            mb         <= mb + 13'd1;
            pred_start <= 1'b1;
            state      <= S_START;
            if (mb_col == 13'(MBW - 1)) begin
              mb_col <= '0;
              mb_row <= mb_row + 13'd1;
            end else begin
              mb_col <= mb_col + 13'd1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intra16_mb_scheduler.sv
// Self-checking bench: a 256x256 instance (reset, modes, addressing, backpressure)
// and a 32x32 instance (full-frame timing, ignored frame_start / pred_done).
module tb_intra16_mb_scheduler;

  typedef struct {
    logic [15:0] v;
    logic [15:0] h;
    logic [15:0] dc;
    logic [1:0]  mode;
  } mb_vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 256x256 instance
  logic        frame_start, busy, frame_done, pred_start, pred_done;
  logic [12:0] pred_mb, mode_addr;
  logic [15:0] sad_v, sad_h, sad_dc;
  logic [1:0]  res_sel, mode_data;
  logic [7:0]  res_idx, res_data, fb_data;
  logic        fb_we, fb_ready, mode_we;
  logic [15:0] fb_addr;

  // 32x32 instance
  logic        s_frame_start, s_busy, s_frame_done, s_pred_start, s_pred_done;
  logic [12:0] s_pred_mb, s_mode_addr;
  logic [15:0] s_sad_v, s_sad_h, s_sad_dc;
  logic [1:0]  s_res_sel, s_mode_data;
  logic [7:0]  s_res_idx, s_res_data, s_fb_data;
  logic        s_fb_we, s_fb_ready, s_mode_we;
  logic [9:0]  s_fb_addr;

  function automatic logic [7:0] res_model(input logic [1:0] sel, input logic [7:0] i);
    return i ^ (8'(sel) * 8'h5b);
  endfunction

  function automatic int addr_model(input int mbn, input int i);
    return ((mbn / 16) * 16 + i / 16) * 256 + (mbn % 16) * 16 + i % 16;
  endfunction

  assign res_data   = res_model(res_sel, res_idx);
  assign s_res_data = res_model(s_res_sel, s_res_idx);

  intra16_mb_scheduler dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .pred_start(pred_start), .pred_mb(pred_mb),
    .pred_done(pred_done), .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc),
    .res_sel(res_sel), .res_idx(res_idx), .res_data(res_data), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready), .mode_we(mode_we),
    .mode_addr(mode_addr), .mode_data(mode_data)
  );

  intra16_mb_scheduler #(.FRAME_W(32), .FRAME_H(32)) dut_s (
    .clk(clk), .reset(reset), .frame_start(s_frame_start), .busy(s_busy),
    .frame_done(s_frame_done), .pred_start(s_pred_start), .pred_mb(s_pred_mb),
    .pred_done(s_pred_done), .sad_v(s_sad_v), .sad_h(s_sad_h), .sad_dc(s_sad_dc),
    .res_sel(s_res_sel), .res_idx(s_res_idx), .res_data(s_res_data), .fb_we(s_fb_we),
    .fb_addr(s_fb_addr), .fb_data(s_fb_data), .fb_ready(s_fb_ready), .mode_we(s_mode_we),
    .mode_addr(s_mode_addr), .mode_data(s_mode_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Per-MB SAD vectors and expected mode, reused cyclically (MB n uses entry n % 8).
  mb_vec_t vecs[8];
  mb_vec_t cur;
  logic [3:0] bp_pat = 4'b1001;

  int   cyc = 0, pd_at = -1, exp_mb = 0, pred_start_cnt = 0, frame_done_cnt = 0;
  int   accepts = 0, we_cycles = 0, bad_seq = 0, mode_we_cnt = 0;
  int   first_addr = 0, last_addr = 0, fs_cyc = 0;
  logic bp_on = 1'b0, stalled_prev = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_idx, prev_data;

  task automatic end_of_mb();
    check("mb_writes", accepts, 256);
    check("mb_seq_errs", bad_seq, 0);
    check("mb_mode_we_pulses", mode_we_cnt, 1);
    check("mb_write_cycles", we_cycles, bp_on ? 512 : 256);
    case (exp_mb)
      0:   begin check("mb0_first", first_addr, 0);       check("mb0_last", last_addr, 3855);    end
      1:   begin check("mb1_first", first_addr, 16);      check("mb1_last", last_addr, 3871);    end
      16:  begin check("mb16_first", first_addr, 4096);   check("mb16_last", last_addr, 7951);   end
      255: begin check("mb255_first", first_addr, 61680); check("mb255_last", last_addr, 65535); end
      default: ;
    endcase
  endtask

  // One clock of the 256x256 bench: observe at the falling edge, then drive inputs.
  task automatic big_cycle();
    @(negedge clk);
    cyc++;
    if (pred_start) begin
      pred_start_cnt++;
      exp_mb = pred_start_cnt - 1;
      check("pred_mb", 32'(pred_mb), 32'(exp_mb));
      cur          = vecs[exp_mb % 8];
      pd_at        = cyc + 1;
      bp_on        = (exp_mb == 2);
      accepts      = 0;
      we_cycles    = 0;
      bad_seq      = 0;
      mode_we_cnt  = 0;
      stalled_prev = 1'b0;
    end
    if (mode_we) begin
      mode_we_cnt++;
      check("mode_addr", 32'(mode_addr), 32'(exp_mb));
      check("mode_data", 32'(mode_data), 32'(cur.mode));
    end
    if (fb_we) begin
      if (stalled_prev && (fb_addr !== prev_addr || res_idx !== prev_idx || fb_data !== prev_data))
        bad_seq++;
      if (res_idx !== 8'(accepts) || res_sel !== cur.mode ||
          fb_addr !== 16'(addr_model(exp_mb, accepts)) ||
          fb_data !== res_model(cur.mode, 8'(accepts)))
        bad_seq++;
      fb_ready = bp_on ? bp_pat[we_cycles % 4] : 1'b1;
      if (fb_ready) begin
        if (accepts == 0)   first_addr = int'(fb_addr);
        if (accepts == 255) last_addr  = int'(fb_addr);
        accepts++;
      end
      stalled_prev = !fb_ready;
      prev_addr    = fb_addr;
      prev_idx     = res_idx;
      prev_data    = fb_data;
      we_cycles++;
    end else begin
      fb_ready = 1'b1;
      if (prev_we) end_of_mb();
    end
    prev_we = fb_we;
    if (frame_done) frame_done_cnt++;
    pred_done = (cyc == pd_at);
    sad_v     = cur.v;
    sad_h     = cur.h;
    sad_dc    = cur.dc;
  endtask

  task automatic check_big_idle(input string tag);
    check({tag, "_ctrl"}, {busy, pred_start, fb_we, mode_we, frame_done}, 0);
    check({tag, "_pred_mb"}, pred_mb, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_res_idx_sel"}, {res_idx, res_sel}, 0);
    check({tag, "_data"}, {fb_data, mode_data, mode_addr}, 0);
  endtask

  // 32x32 bench state
  int   scyc = 0, s_pd_at = -1, s_ps_cnt = 0, s_first_ps = 0, s_fs_cyc = 0, s_done_cyc = 0;
  int   s_acc = 0, s_we_cnt = 0, s_bad = 0, s_mwe_cnt = 0, s_fd_cnt = 0;
  int   s_first = -1, s_last = -1;
  logic s_stray;

  task automatic s_cycle();
    @(negedge clk);
    scyc++;
    if (s_pred_start) begin
      s_ps_cnt++;
      check("s_pred_mb", 32'(s_pred_mb), 32'(s_ps_cnt - 1));
      if (s_ps_cnt == 1) begin
        s_first_ps = scyc;
        check("s_busy_running", s_busy, 1);
      end
      s_pd_at = scyc + 3;
      s_acc   = 0;
    end
    if (s_mode_we) begin
      s_mwe_cnt++;
      check("s_mode_data", 32'(s_mode_data), 0);
    end
    s_stray = 1'b0;
    if (s_fb_we) begin
      s_we_cnt++;
      if (s_fb_data !== res_model(2'd0, 8'(s_acc)) || s_res_idx !== 8'(s_acc) || s_res_sel !== 2'd0)
        s_bad++;
      if (s_ps_cnt == 4 && s_acc == 0)   s_first = int'(s_fb_addr);
      if (s_ps_cnt == 4 && s_acc == 255) s_last  = int'(s_fb_addr);
      s_stray = (s_ps_cnt == 2 && s_acc == 5);
      s_acc++;
    end
    if (s_frame_done) begin
      s_fd_cnt++;
      s_done_cyc = scyc;
    end
    s_pred_done = (scyc == s_pd_at) || s_stray;
    s_sad_v     = s_stray ? 16'd50 : 16'd10;
    s_sad_h     = s_stray ? 16'd40 : 16'd20;
    s_sad_dc    = s_stray ? 16'd5  : 16'd30;
  endtask

  initial begin
    vecs[0] = '{16'd100,   16'd50,    16'd70,    2'd1};
    vecs[1] = '{16'd40,    16'd40,    16'd40,    2'd0};
    vecs[2] = '{16'd90,    16'd90,    16'd10,    2'd2};
    vecs[3] = '{16'd30,    16'd20,    16'd20,    2'd1};
    vecs[4] = '{16'd5,     16'd9,     16'd5,     2'd0};
    vecs[5] = '{16'h8000,  16'h7fff,  16'hffff,  2'd1};
    vecs[6] = '{16'd65535, 16'd65535, 16'd65534, 2'd2};
    vecs[7] = '{16'd0,     16'd1,     16'd2,     2'd0};
    cur = vecs[0];

    reset = 1'b0;
    frame_start = 1'b0; pred_done = 1'b0; fb_ready = 1'b1;
    sad_v = '0; sad_h = '0; sad_dc = '0;
    s_frame_start = 1'b0; s_pred_done = 1'b0; s_fb_ready = 1'b1;
    s_sad_v = '0; s_sad_h = '0; s_sad_dc = '0;

    repeat (3) @(negedge clk);
    check_big_idle("reset");
    check("s_reset_ctrl", {s_busy, s_pred_start, s_fb_we, s_mode_we, s_frame_done}, 0);
    reset = 1'b1;

    // Reset mid-frame: start, run into the WRITE of MB 3, then drop reset.
    big_cycle();
    frame_start = 1'b1;
    fs_cyc = cyc;
    big_cycle();
    frame_start = 1'b0;
    check("start_latency", {pred_start, busy}, 2'b11);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        big_cycle();
        if (exp_mb == 3 && fb_we && accepts == 20) begin
          reached = 1'b1;
          break;
        end
      end
      check("reached_mb3_write", reached, 1);
    end
    reset = 1'b0;
    #1;
    check_big_idle("async_reset");
    pred_done = 1'b0; prev_we = 1'b0; stalled_prev = 1'b0;
    pred_start_cnt = 0; frame_done_cnt = 0; pd_at = -1;
    repeat (3) big_cycle();
    reset = 1'b1;
    repeat (20) big_cycle();
    check("no_frame_done_after_reset", frame_done_cnt, 0);
    check("idle_after_reset", {busy, pred_start}, 0);

    // Full 256x256 frame: modes, addressing, backpressure on MB 2.
    big_cycle();
    frame_start = 1'b1;
    big_cycle();
    frame_start = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      big_cycle();
      if (frame_done_cnt > 0) break;
    end
    check("frame_done_seen", frame_done_cnt, 1);
    check("mb_count", pred_start_cnt, 256);
    repeat (3) big_cycle();
    check("busy_after_frame", busy, 0);
    check("single_frame_done", frame_done_cnt, 1);

    // 32x32 frame: timing, ignored frame_start while busy, stray pred_done during WRITE.
    s_cycle();
    s_frame_start = 1'b1;
    s_fs_cyc = scyc;
    s_cycle();
    s_frame_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s_cycle();
      s_frame_start = (scyc == s_fs_cyc + 100);
      if (s_fd_cnt > 0) break;
    end
    s_frame_start = 1'b0;
    repeat (20) s_cycle();
    check("s_frame_done_count", s_fd_cnt, 1);
    check("s_pred_start_count", s_ps_cnt, 4);
    check("s_mode_we_count", s_mwe_cnt, 4);
    check("s_write_count", s_we_cnt, 1024);
    check("s_write_errs", s_bad, 0);
    check("s_start_latency", s_first_ps - s_fs_cyc, 1);
    // Cycles from the first pred_start through frame_done, both inclusive.
    check("s_frame_cycles", s_done_cyc - s_first_ps + 1, 4 * 262 + 1);
    check("s_mb3_first", s_first, 528);
    check("s_mb3_last", s_last, 1023);
    check("s_busy_after", s_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
